tbuf_bus_arbiter: RTL and testbench

- Round-robin arbiter sharing one tri-state bus between N requesters; each requester drives the bus through its own TBUFX1/TBUFX2 bank.
- Sequences the bank enables so no two banks ever drive in the same cycle. Every change of owner inserts one turnaround cycle with all enables low.
- Hold-timeout counter prevents one requester from monopolising the bus while others wait.

---
 rtl/tbuf_arb_pkg.sv | 20 ++
 rtl/tbuf_arb_rr_pick.sv | 31 +++
 rtl/tbuf_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_tbuf_bus_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/tbuf_arb_pkg.sv
// Shared types and helpers for the tri-state bus arbiter.
package tbuf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        TURN = 2'b01,
        OWN  = 2'b10
    } arb_state_e;

    // Index of the highest set bit; callers only pass one-hot or zero vectors.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tbuf_arb_rr_pick.sv
// Combinational round-robin picker: searches req starting just after ptr, wrapping.
module tbuf_arb_rr_pick
    import tbuf_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             valid,
    output logic [IW-1:0]    idx,
    output logic [N_REQ-1:0] onehot
);

    int cand;

    always_comb begin
        onehot = '0;
        valid  = 1'b0;
        cand   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(ptr) + i) % N_REQ;
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                onehot[cand] = 1'b1;
            end
        end
        idx = IW'(onehot_to_idx(8'(onehot)));
    end

endmodule

// File: rtl/tbuf_bus_arbiter.sv
// Round-robin owner sequencing for a shared tri-state bus, with one dead
// turnaround cycle between owners and a hold timeout under contention.
module tbuf_bus_arbiter
    import tbuf_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    parameter int IW       = $clog2(N_REQ)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] GNT,
    output logic [N_REQ-1:0] EN,
    output logic [IW-1:0]    OWNER,
    output logic             BUSY
);

    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] en_q, en_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] pick_req, pick_oh;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic             own_req, others_req, release_own;

    // While owning, the current owner is masked so a release never re-picks it.
    assign pick_req    = (state_q == OWN) ? (REQ & ~gnt_q) : REQ;
    assign own_req     = |(REQ & gnt_q);
    assign others_req  = |(REQ & ~gnt_q);
    assign release_own = !own_req ||
                         ((MAX_HOLD != 0) && (hold_q == HOLD_LAST) && others_req);

    tbuf_arb_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req    (pick_req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        en_d    = en_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = TURN;
                    owner_d = pick_idx;
                    ptr_d   = pick_idx;
                    gnt_d   = pick_oh;
                    en_d    = '0;
                    busy_d  = 1'b1;
                end
            end
            TURN: begin
                state_d = OWN;
                en_d    = gnt_q;
                hold_d  = '0;
            end
            OWN: begin
                if (release_own) begin
                    en_d = '0;
                    if (pick_valid) begin
                        state_d = TURN;
                        owner_d = pick_idx;
                        ptr_d   = pick_idx;
                        gnt_d   = pick_oh;
                    end else begin
                        state_d = IDLE;
                        owner_d = '0;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                    end
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
                gnt_d   = '0;
                en_d    = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= IW'(N_REQ - 1);
            hold_q  <= '0;
            gnt_q   <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    assign GNT   = gnt_q;
    assign EN    = en_q;
    assign OWNER = owner_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// Directed vector bench for tbuf_bus_arbiter (N_REQ=4, MAX_HOLD=4).
module tb_tbuf_bus_arbiter;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] REQ = '0;
    logic [3:0] GNT, EN;
    logic [1:0] OWNER;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [3:0] en;
        logic [1:0] own;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    tbuf_bus_arbiter #(.N_REQ(4), .MAX_HOLD(4)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ   (REQ),
        .GNT   (GNT),
        .EN    (EN),
        .OWNER (OWNER),
        .BUSY  (BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic void add(input logic rst, input logic [3:0] req, input logic [3:0] gnt,
                                input logic [3:0] en, input logic [1:0] own, input logic busy);
        vec_t v;
        v.rst = rst; v.req = req; v.gnt = gnt; v.en = en; v.own = own; v.busy = busy;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %b want %b", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [3:0] gnt,
                           input logic [3:0] en, input logic [1:0] own, input logic busy);
        chk({tag, ".gnt"}, idx, GNT, gnt);
        chk({tag, ".en"}, idx, EN, en);
        chk({tag, ".owner"}, idx, {2'b00, OWNER}, {2'b00, own});
        chk({tag, ".busy"}, idx, {3'b000, BUSY}, {3'b000, busy});
    endtask

    // Bus safety properties, sampled mid-cycle whenever reset is released.
    logic [3:0] prev_en = '0;
    always @(negedge CLK) begin
        if (!RST) begin
            checks++;
            if (!$onehot0(EN) || !$onehot0(GNT) || ((EN & ~GNT) != 4'b0) ||
                (prev_en != 4'b0 && EN != 4'b0 && prev_en != EN)) begin
                errors++;
                $display("FAIL bus_props got en=%b gnt=%b prev_en=%b want one-hot safe handover",
                         EN, GNT, prev_en);
            end
            prev_en <= EN;
        end else begin
            prev_en <= '0;
        end
    end

    initial begin
        // Single requester: grant, enable, release to idle.
        add(0, 4'b0001, 4'b0001, 4'b0000, 0, 1);
        add(0, 4'b0001, 4'b0001, 4'b0001, 0, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        // All requesting: 0,1,2,3,0 with 4 OWN cycles and a dead TURN cycle each.
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        for (int k = 0; k < 5; k++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (k % 4);
            add(0, 4'b1111, oh, 4'b0000, 2'(k % 4), 1);
            for (int c = 0; c < 4; c++) add(0, 4'b1111, oh, oh, 2'(k % 4), 1);
        end
        // Lone requester 2 for 20 cycles: never preempted.
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0100, 4'b0100, 4'b0000, 2, 1);
        for (int c = 0; c < 19; c++) add(0, 4'b0100, 4'b0100, 4'b0100, 2, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        // Requester 1 owns, requester 3 joins: preempt after 4 OWN cycles.
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0010, 4'b0010, 4'b0000, 1, 1);
        add(0, 4'b0010, 4'b0010, 4'b0010, 1, 1);
        for (int c = 0; c < 3; c++) add(0, 4'b1010, 4'b0010, 4'b0010, 1, 1);
        add(0, 4'b1010, 4'b1000, 4'b0000, 3, 1);
        add(0, 4'b1010, 4'b1000, 4'b1000, 3, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);

        RST = 1'b1;
        REQ = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk_all("reset", 0, 4'b0000, 4'b0000, 0, 0);

        foreach (tbl[i]) begin
            RST = tbl[i].rst;
            REQ = tbl[i].req;
            @(posedge CLK);
            #1;
            chk_all("tbl", i, tbl[i].gnt, tbl[i].en, tbl[i].own, tbl[i].busy);
        end

        // Async reset mid-OWN, then pointer must be back at N_REQ-1.
        RST = 1'b1; REQ = '0;
        @(posedge CLK); #1;
        RST = 1'b0; REQ = 4'b0100;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk_all("arst_own", 0, 4'b0100, 4'b0100, 2, 1);
        #3 RST = 1'b1;
        #1;
        chk_all("arst_now", 0, 4'b0000, 4'b0000, 0, 0);
        @(posedge CLK); #1;
        RST = 1'b0; REQ = 4'b1010;
        @(posedge CLK); #1;
        chk_all("arst_regrant", 0, 4'b0010, 4'b0000, 1, 1);
        @(posedge CLK); #1;
        chk_all("arst_regrant", 1, 4'b0010, 4'b0010, 1, 1);

        // One-cycle pulse: tenure still starts, lasts one OWN cycle.
        REQ = '0;
        @(posedge CLK); #1;
        chk_all("pulse_idle", 0, 4'b0000, 4'b0000, 0, 0);
        REQ = 4'b0001;
        @(posedge CLK); #1;
        chk_all("pulse", 0, 4'b0001, 4'b0000, 0, 1);
        REQ = 4'b0000;
        @(posedge CLK); #1;
        chk_all("pulse", 1, 4'b0001, 4'b0001, 0, 1);
        @(posedge CLK); #1;
        chk_all("pulse", 2, 4'b0000, 4'b0000, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
